fu_issue_stage: RTL and testbench

- Operand-issue and writeback stage that sits directly upstream and downstream of the combinational function unit.
- Accepts decoded micro-ops over a valid/ready handshake and reads operands from an internal register file.
- Registers a, b, fs and sh into the function unit, then captures fout and the V/C/N/Z flags.
- Writes the result back to the register file and a result port; the flag register is updated on request.

---
 rtl/fu_pkg.sv | 18 +
 rtl/fu_regfile.sv | 22 ++
 rtl/fu_issue_stage.sv | 110 +++++++++++
 tb/tb_fu_issue_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// fu_pkg: function-select encodings, flag bit indices and the EX-slot micro-op type.
package fu_pkg;
  typedef enum logic [3:0] {
    FS_PASS, FS_INC, FS_ADD, FS_ADDC, FS_ADDNOT, FS_SUB, FS_DEC,
    FS_AND, FS_OR, FS_XOR, FS_NOT, FS_MOVB, FS_SHL, FS_SHR
  } fs_e;
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  typedef struct packed {
    fs_e         fs;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic        setf;
  } uop_t;
endpackage

// File: rtl/fu_regfile.sv
// fu_regfile: NREG x 32 register file, two async read ports, one sync write port, r0 hardwired to zero.
module fu_regfile #(
  parameter int NREG = 8,
  parameter int RW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [RW-1:0] wa_i,
  input  logic [31:0]   wd_i,
  input  logic [RW-1:0] ra_a_i,
  input  logic [RW-1:0] ra_b_i,
  output logic [31:0]   rd_a_o,
  output logic [31:0]   rd_b_o
);
  logic [31:0] regs_q [NREG];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else if (we_i && wa_i != '0) regs_q[wa_i] <= wd_i;
  assign rd_a_o = ra_a_i == '0 ? '0 : regs_q[ra_a_i];
  assign rd_b_o = ra_b_i == '0 ? '0 : regs_q[ra_b_i];
endmodule

// File: rtl/fu_issue_stage.sv
// fu_issue_stage: operand issue into the combinational function unit and result writeback.
// FU_ISSUE_FWD_EN: forward the EX result to dependent sources instead of stalling one cycle.
module fu_issue_stage
  import fu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int RW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_fs,
  input  logic [4:0]    in_sh,
  input  logic [RW-1:0] in_ra,
  input  logic [RW-1:0] in_rb,
  input  logic [RW-1:0] in_rd,
  input  logic          in_use_imm,
  input  logic [31:0]   in_imm,
  input  logic          in_setf,
  output logic [3:0]    fu_fs,
  output logic [4:0]    fu_sh,
  output logic [31:0]   fu_a,
  output logic [31:0]   fu_b,
  input  logic [31:0]   fu_fout,
  input  logic          fu_v,
  input  logic          fu_c,
  input  logic          fu_n,
  input  logic          fu_z,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_rd,
  output logic [31:0]   res_data,
  output logic [3:0]    flags
);
  uop_t          ex_q, ex_d;
  logic          ex_valid_q, ex_valid_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [3:0]    flags_q, flags_d, fu_flags;
  logic [31:0]   ra_data, rb_data, a_val, rb_val;
  logic          hazard_stall, accept, retire;

  fu_regfile #(.NREG(NREG), .RW(RW)) u_rf (
    .clk(clk), .rst(rst), .we_i(retire), .wa_i(rd_q), .wd_i(fu_fout),
    .ra_a_i(in_ra), .ra_b_i(in_rb), .rd_a_o(ra_data), .rd_b_o(rb_data)
  );

`ifdef FU_ISSUE_FWD_EN
  logic fwd_ok;
  assign fwd_ok       = ex_valid_q && rd_q != '0;
  assign hazard_stall = 1'b0;
  assign a_val        = fwd_ok && in_ra == rd_q ? fu_fout : ra_data;
  assign rb_val       = fwd_ok && in_rb == rd_q ? fu_fout : rb_data;
`else
  logic hazard;
  assign hazard       = ex_valid_q && rd_q != '0 && (in_ra == rd_q || (!in_use_imm && in_rb == rd_q));
  assign hazard_stall = in_valid && hazard;
  assign a_val        = ra_data;
  assign rb_val       = rb_data;
`endif

  assign in_ready   = !ex_valid_q || (res_ready && !hazard_stall);
  assign accept     = in_valid && in_ready;
  assign retire     = ex_valid_q && res_ready;
  assign ex_valid_d = accept ? 1'b1 : retire ? 1'b0 : ex_valid_q;
  assign flags_d    = retire && ex_q.setf ? fu_flags : flags_q;

  always_comb begin
    fu_flags         = '0;
    fu_flags[FLAG_V] = fu_v;
    fu_flags[FLAG_C] = fu_c;
    fu_flags[FLAG_N] = fu_n;
    fu_flags[FLAG_Z] = fu_z;
  end

  always_comb begin
    ex_d = ex_q;
    rd_d = rd_q;
    if (accept) begin
      ex_d.fs   = fs_e'(in_fs);
      ex_d.sh   = in_sh;
      ex_d.a    = a_val;
      ex_d.b    = in_use_imm ? in_imm : rb_val;
      ex_d.setf = in_setf;
      rd_d      = in_rd;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      rd_q       <= '0;
      flags_q    <= '0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      rd_q       <= rd_d;
      flags_q    <= flags_d;
    end

  assign fu_fs     = ex_q.fs;
  assign fu_sh     = ex_q.sh;
  assign fu_a      = ex_q.a;
  assign fu_b      = ex_q.b;
  assign res_valid = ex_valid_q;
  assign res_rd    = rd_q;
  assign res_data  = fu_fout;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fu_issue_stage.sv
// tb_fu_issue_stage: directed vector table plus hazard, backpressure, r0 and reset sequences.
module tb_fu_issue_stage;
  import fu_pkg::*;
`ifdef FU_ISSUE_FWD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_use_imm = 1'b0, in_setf = 1'b0;
  logic [3:0] in_fs = '0, fu_fs, flags;
  logic [4:0] in_sh = '0, fu_sh;
  logic [2:0] in_ra = '0, in_rb = '0, in_rd = '0, res_rd;
  logic [31:0] in_imm = '0, fu_a, fu_b, fu_fout, res_data;
  logic fu_v, fu_c, fu_n, fu_z, res_valid, res_ready = 1'b1;
  int n_vec = 0, n_err = 0, st;

  fu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fs(in_fs), .in_sh(in_sh),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_setf(in_setf), .fu_fs(fu_fs), .fu_sh(fu_sh), .fu_a(fu_a), .fu_b(fu_b), .fu_fout(fu_fout),
    .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z), .res_valid(res_valid), .res_ready(res_ready),
    .res_rd(res_rd), .res_data(res_data), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference function unit driven by the stage's registered outputs.
  logic [31:0] y;
  logic ci, arith;
  logic [32:0] sum;
  always_comb begin
    y = fu_b;
    ci = 1'b0;
    arith = 1'b1;
    fu_fout = '0;
    case (fu_fs)
      FS_INC: begin y = '0; ci = 1'b1; end
      FS_ADD: ;
      FS_ADDC: ci = flags[2];
      FS_ADDNOT: y = ~fu_b;
      FS_SUB: begin y = ~fu_b; ci = 1'b1; end
      FS_DEC: y = '1;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, fu_a} + {1'b0, y} + {32'd0, ci};
    case (fu_fs)
      FS_PASS: fu_fout = fu_a;
      FS_AND:  fu_fout = fu_a & fu_b;
      FS_OR:   fu_fout = fu_a | fu_b;
      FS_XOR:  fu_fout = fu_a ^ fu_b;
      FS_NOT:  fu_fout = ~fu_a;
      FS_MOVB: fu_fout = fu_b;
      FS_SHL:  fu_fout = fu_a << fu_sh;
      FS_SHR:  fu_fout = fu_a >> fu_sh;
      default: fu_fout = arith ? sum[31:0] : '0;
    endcase
    fu_c = arith && sum[32];
    fu_v = arith && (fu_a[31] == y[31]) && (sum[31] != fu_a[31]);
    fu_n = fu_fout[31];
    fu_z = fu_fout == '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one micro-op, wait (bounded) for acceptance; returns one cycle after the accept edge.
  task automatic send(input fs_e fs, input logic [4:0] sh, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] rd, input logic ui, input logic [31:0] imm, input logic sf,
                      output int stalls);
    int n = 0;
    in_valid = 1'b1; in_fs = fs; in_sh = sh; in_ra = ra; in_rb = rb; in_rd = rd;
    in_use_imm = ui; in_imm = imm; in_setf = sf;
    #1;
    while (!in_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 8) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stalls = n;
  endtask

  typedef struct {
    fs_e fs; logic [4:0] sh; logic [2:0] ra, rb, rd; logic ui; logic [31:0] imm; logic sf;
    logic [31:0] res; logic [3:0] fl;
  } vec_t;
  vec_t tv [12];

  initial begin
    tv[0]  = '{FS_MOVB,   5'd0, 3'd0, 3'd0, 3'd1, 1'b1, 32'd5,        1'b0, 32'd5,        4'b0000};
    tv[1]  = '{FS_ADD,    5'd0, 3'd1, 3'd1, 3'd2, 1'b0, 32'd0,        1'b0, 32'd10,       4'b0000};
    tv[2]  = '{FS_MOVB,   5'd0, 3'd0, 3'd0, 3'd3, 1'b1, 32'd5,        1'b0, 32'd5,        4'b0000};
    tv[3]  = '{FS_SUB,    5'd0, 3'd1, 3'd3, 3'd4, 1'b0, 32'd0,        1'b1, 32'd0,        4'b0101};
    tv[4]  = '{FS_MOVB,   5'd0, 3'd0, 3'd0, 3'd5, 1'b1, 32'h0000000F, 1'b0, 32'h0000000F, 4'b0101};
    tv[5]  = '{FS_SHL,    5'd4, 3'd5, 3'd0, 3'd6, 1'b1, 32'd0,        1'b0, 32'h000000F0, 4'b0101};
    tv[6]  = '{FS_PASS,   5'd0, 3'd2, 3'd0, 3'd7, 1'b0, 32'd0,        1'b0, 32'd10,       4'b0101};
    tv[7]  = '{FS_XOR,    5'd0, 3'd6, 3'd0, 3'd7, 1'b1, 32'h000000FF, 1'b1, 32'h0000000F, 4'b0000};
    tv[8]  = '{FS_MOVB,   5'd0, 3'd0, 3'd0, 3'd1, 1'b1, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 4'b0000};
    tv[9]  = '{FS_ADD,    5'd0, 3'd1, 3'd1, 3'd3, 1'b0, 32'd0,        1'b1, 32'hFFFFFFFE, 4'b1010};
    tv[10] = '{FS_MOVB,   5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'b1010};
    tv[11] = '{FS_PASS,   5'd0, 3'd0, 3'd0, 3'd2, 1'b0, 32'd0,        1'b0, 32'd0,        4'b1010};

    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_res_rd", res_rd, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send(tv[i].fs, tv[i].sh, tv[i].ra, tv[i].rb, tv[i].rd, tv[i].ui, tv[i].imm, tv[i].sf, st);
      #1;
      chk($sformatf("v%0d_res_valid", i), res_valid, 1);
      chk($sformatf("v%0d_res_data", i), res_data, tv[i].res);
      chk($sformatf("v%0d_res_rd", i), res_rd, tv[i].rd);
      chk($sformatf("v%0d_fu_fs", i), fu_fs, tv[i].fs);
      chk($sformatf("v%0d_fu_sh", i), fu_sh, tv[i].sh);
      @(posedge clk); #1;
      chk($sformatf("v%0d_flags", i), flags, tv[i].fl);
      chk($sformatf("v%0d_retired", i), res_valid, 0);
    end

    // Dependent back-to-back pair: bubble only without forwarding.
    send(FS_MOVB, 5'd0, 3'd0, 3'd0, 3'd1, 1'b1, 32'd5, 1'b0, st);
    chk("b2b_first_stall", st, 0);
    send(FS_ADD, 5'd0, 3'd1, 3'd1, 3'd2, 1'b0, 32'd0, 1'b0, st);
    chk("b2b_hazard_stalls", st, EXP_STALL);
    #1;
    chk("b2b_res_data", res_data, 10);
    chk("b2b_res_rd", res_rd, 2);
    @(posedge clk); #1;
    send(FS_PASS, 5'd0, 3'd2, 3'd0, 3'd3, 1'b0, 32'd0, 1'b0, st);
    #1;
    chk("b2b_r2", res_data, 10);
    @(posedge clk); #1;

    // r0 as destination never creates a dependency and stays zero.
    send(FS_MOVB, 5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 32'hDEADBEEF, 1'b0, st);
    send(FS_PASS, 5'd0, 3'd0, 3'd0, 3'd1, 1'b0, 32'd0, 1'b0, st);
    chk("r0_no_stall", st, 0);
    #1;
    chk("r0_fu_a", fu_a, 0);
    chk("r0_res_data", res_data, 0);
    @(posedge clk); #1;

    // Backpressure: slot holds for three cycles, then retire and accept together.
    res_ready = 1'b0;
    send(FS_MOVB, 5'd0, 3'd0, 3'd0, 3'd5, 1'b1, 32'h123, 1'b0, st);
    in_valid = 1'b1; in_fs = FS_PASS; in_sh = 5'd0; in_ra = 3'd6; in_rb = 3'd0; in_rd = 3'd7;
    in_use_imm = 1'b0; in_imm = '0; in_setf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 32'h123);
      chk("bp_fu_b", fu_b, 32'h123);
      chk("bp_fu_fs", fu_fs, FS_MOVB);
      chk("bp_res_rd", res_rd, 5);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("bp_next_rd", res_rd, 7);
    chk("bp_next_data", res_data, 32'hF0);
    @(posedge clk); #1;
    send(FS_PASS, 5'd0, 3'd5, 3'd0, 3'd1, 1'b0, 32'd0, 1'b0, st);
    #1;
    chk("bp_r5_written", res_data, 32'h123);
    @(posedge clk); #1;

    // Asynchronous reset with a micro-op held in EX.
    res_ready = 1'b0;
    send(FS_MOVB, 5'd3, 3'd0, 3'd0, 3'd4, 1'b1, 32'h55, 1'b1, st);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_res_rd", res_rd, 0);
    chk("mid_rst_fu_b", fu_b, 0);
    chk("mid_rst_fu_sh", fu_sh, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    send(FS_PASS, 5'd0, 3'd3, 3'd0, 3'd1, 1'b0, 32'd0, 1'b0, st);
    #1;
    chk("post_rst_r3_fu_a", fu_a, 0);
    chk("post_rst_res_data", res_data, 0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
